// File: rtl/dec2_4e.sv
// dec2_4e: 2-to-4 enabled decoder with registered one-hot output and saturating per-line hit counters
module dec2_4e #(
  parameter int CNT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               e,
  input  logic [1:0]         a,
  input  logic               cnt_clr,
  output logic [3:0]         y_comb,
  output logic [3:0]         y,
  output logic               y_valid,
  output logic [4*CNT_W-1:0] hit_cnt
);
  localparam logic [3:0] IDLE = ACTIVE_LOW ? 4'hf : 4'h0;
  logic [3:0] dec;
  assign dec    = {4{e}} & (4'b0001 << a);
  assign y_comb = ACTIVE_LOW ? ~dec : dec;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y       <= IDLE;
      y_valid <= 1'b0;
    end else begin
      y       <= y_comb;
      y_valid <= e;
    end
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else if (e && a == 2'(i) && cnt != '1) cnt <= cnt + CNT_W'(1);
    assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
  end
endmodule

// File: tb/tb_dec2_4e.sv
// tb_dec2_4e: directed checks of a default decoder and a 2-bit-counter active-low variant
module tb_dec2_4e;
  logic       clk = 1'b0;
  logic       rst, e, cnt_clr;
  logic [1:0] a;
  logic [3:0] yc_d, y_d, yc_s, y_s;
  logic       v_d, v_s;
  logic [63:0] h_d;
  logic [7:0]  h_s;
  int total = 0;
  int bad   = 0;

  dec2_4e #(.CNT_W(16), .ACTIVE_LOW(1'b0)) u_d (
    .clk(clk), .rst(rst), .e(e), .a(a), .cnt_clr(cnt_clr),
    .y_comb(yc_d), .y(y_d), .y_valid(v_d), .hit_cnt(h_d));
  dec2_4e #(.CNT_W(2), .ACTIVE_LOW(1'b1)) u_s (
    .clk(clk), .rst(rst), .e(e), .a(a), .cnt_clr(cnt_clr),
    .y_comb(yc_s), .y(y_s), .y_valid(v_s), .hit_cnt(h_s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; e = 1'b1; a = 2'b11; cnt_clr = 1'b0;
    #2;
    chk("rst_y", y_d, 4'h0);
    chk("rst_v", v_d, 1'b0);
    chk("rst_cnt", h_d, 64'h0);
    chk("rst_y_al", y_s, 4'hf);
    chk("rst_cnt_s", h_s, 8'h0);
    rst = 1'b0; e = 1'b0; a = 2'b00;
    #1 chk("dis0_comb", yc_d, 4'h0);
    chk("dis0_comb_al", yc_s, 4'hf);
    tick;
    chk("dis0_y", y_d, 4'h0);
    chk("dis0_v", v_d, 1'b0);
    a = 2'b10;
    #1 chk("dis2_comb", yc_d, 4'h0);
    tick;
    chk("dis2_y", y_d, 4'h0);
    chk("dis_cnt", h_d, 64'h0);
    e = 1'b1; a = 2'b00;
    #1 chk("en0_comb", yc_d, 4'b0001);
    tick;
    chk("en0_y", y_d, 4'b0001);
    chk("en0_v", v_d, 1'b1);
    a = 2'b01;
    #1 chk("en1_comb", yc_d, 4'b0010);
    tick;
    chk("en1_y", y_d, 4'b0010);
    a = 2'b10;
    #1 chk("en2_comb", yc_d, 4'b0100);
    tick;
    chk("en2_y", y_d, 4'b0100);
    a = 2'b11;
    #1 chk("en3_comb", yc_d, 4'b1000);
    chk("en3_comb_al", yc_s, 4'b0111);
    tick;
    chk("en3_y", y_d, 4'b1000);
    chk("en3_y_al", y_s, 4'b0111);
    chk("en_cnt", h_d, 64'h0001_0001_0001_0001);
    e = 1'b0; a = 2'b00; tick;
    chk("seq0_y", y_d, 4'h0);
    chk("seq0_v", v_d, 1'b0);
    e = 1'b1; a = 2'b00; tick;
    chk("seq1_y", y_d, 4'b0001);
    e = 1'b0; a = 2'b10; tick;
    chk("seq2_y", y_d, 4'h0);
    e = 1'b1; a = 2'b10; tick;
    chk("seq3_y", y_d, 4'b0100);
    chk("seq3_v", v_d, 1'b1);
    chk("seq_cnt", h_d, 64'h0001_0002_0001_0002);
    chk("seq_cnt_s", h_s, {2'd1, 2'd2, 2'd1, 2'd2});
    a = 2'b11;
    for (int k = 0; k < 5; k++) tick;
    chk("sat_cnt_s", h_s, {2'd3, 2'd2, 2'd1, 2'd2});
    chk("nosat_cnt", h_d, 64'h0006_0002_0001_0002);
    cnt_clr = 1'b1; tick;
    cnt_clr = 1'b0;
    chk("clr_cnt", h_d, 64'h0);
    chk("clr_cnt_s", h_s, 8'h0);
    chk("clr_y", y_d, 4'b1000);
    chk("clr_v", v_d, 1'b1);
    a = 2'b01; tick;
    chk("post_clr_cnt", h_d, 64'h0000_0000_0001_0000);
    #2 rst = 1'b1;
    #1;
    chk("arst_y", y_d, 4'h0);
    chk("arst_y_al", y_s, 4'hf);
    chk("arst_v", v_s, 1'b0);
    chk("arst_cnt", h_d, 64'h0);
    rst = 1'b0; e = 1'b1; a = 2'b01;
    #1 chk("al_comb", yc_s, 4'b1101);
    tick;
    chk("al_y", y_s, 4'b1101);
    chk("al_v", v_s, 1'b1);
    chk("al_cnt_s", h_s, {2'd0, 2'd0, 2'd1, 2'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
